spi_wb_ctrl: RTL and testbench
==============================

Name: spi_wb_ctrl

Overview:
SPI slave (mode 0, MSB first) bridging an external SPI master to an 8-bit Wishbone-style master port, which reaches the on-chip register block.
- Each transaction is two bytes: a command/address byte, then a data byte.
- Read data returns on MISO during the data byte; write data drives a Wishbone write after the data byte completes.
- SPI inputs are oversampled in the single system clock domain.

Parameters:
SYNC_STAGES, 2, synchronizer depth for spi_sck, spi_ss and spi_mosi (minimum 2)

Ports:
clk  in  1  system clock; also the Wishbone clock
wb_rst_i  in  1  asynchronous, active-low reset
spi_sck  in  1  SPI clock from master; idles low
spi_ss  in  1  slave select, active low
spi_mosi  in  1  serial data in
spi_miso  out  1  serial data out; driven low when spi_ss high (no tristate)
wb_addr_o  out  8  Wishbone address
wb_dat_i  in  8  Wishbone read data
wb_dat_o  out  8  Wishbone write data
wb_stb_o  out  1  Wishbone strobe
wb_ack_i  in  1  Wishbone acknowledge; may be combinational from wb_stb_o
wb_we_o  out  1  Wishbone write enable (1 = write)

Behaviour:
- Reset (wb_rst_i = 0, asynchronous): all outputs 0, shift register 0x00, bit counter 0, state IDLE.
- spi_sck, spi_ss and spi_mosi each pass through SYNC_STAGES flops.
- SCK rising edge = synchronized sck is 1 and its previous sample was 0.
- Timing requirements on the SPI master:
  - SCK high and low times at least 1 clk each.
  - For reads, at least SYNC_STAGES+3 clk plus Wishbone wait states between the last SCK rise of byte 0 and the first SCK rise of byte 1.
- Shift register, 8 bits:
  - On each SCK rising edge, shift left with synchronized MOSI into bit 0.
  - spi_miso = sr[7] while SS is low.
- Bit counter, 3 bits:
  - Increments on each SCK rising edge and wraps 7 -> 0.
  - The byte is complete on the rise where the counter wraps.
- State machine:
  - IDLE: SS high. Bit counter held at 0; shift register held at 0x00. SS low -> CMD.
  - CMD: on byte complete, latch int_cmd = byte[7] (1 = write) and int_addr = {1'b0, byte[6:0]}.
    - cmd = 0 -> RD_REQ.
    - cmd = 1 -> DATA.
  - RD_REQ: wb_addr_o = int_addr, wb_we_o = 0, wb_stb_o = 1.
    - Strobe held until a cycle with wb_ack_i = 1.
    - In that cycle, load wb_dat_i into the shift register (spi_ld); strobe drops the next cycle -> DATA.
  - DATA: shift 8 bits.
    - On byte complete with cmd = 1: latch wb_dat_o = byte -> WR_REQ.
    - On byte complete with cmd = 0 -> CMD.
  - WR_REQ: wb_addr_o = int_addr, wb_dat_o = data, wb_we_o = 1, wb_stb_o = 1 until ack.
    - Then strobe drops -> CMD; shift register cleared to 0x00.
- On entry to CMD from IDLE, the shift register is 0x00, so MISO is 0 throughout the command byte.
- wb_addr_o, wb_dat_o and wb_we_o are registered and hold their last values after the strobe drops.
- Strobe is registered; a combinational ack in the first strobe cycle gives a one-cycle strobe.
- SS deasserted (synchronized) mid-byte or between bytes:
  - Counter cleared, go to IDLE, partial byte discarded, no Wishbone cycle started.
  - Exception: a strobe already asserted stays high until ack, then IDLE.
- SS low with further bytes: transactions repeat (CMD, DATA, CMD, ...) without an SS toggle.
- SCK edges during RD_REQ/WR_REQ are a master protocol error. They still shift and count; no recovery beyond SS deassertion is required.

Decomposition:
- Shared package: state enum (IDLE, CMD, RD_REQ, DATA, WR_REQ) and constant CMD_WRITE_BIT = 7.
- One sub-module, spi_shift_reg:
  - Inputs: clk, rst, shift enable, serial in, parallel load, parallel data.
  - Outputs: 8-bit contents, serial out = MSB.
- Synchronizers and edge detect stay inline.

Test Plan:
1. Reset: hold wb_rst_i = 0 -> all outputs 0; release with SS high -> no wb_stb_o, spi_miso = 0.
2. Read, ack tied to strobe, wb_dat_i = 0xA5: send 0x05, 0x00 under one SS low.
   - Exactly one strobe cycle with wb_we_o = 0 and wb_addr_o = 0x05.
   - MISO returns 0x00 during byte 0 and 0xA5 during byte 1.
3. Write: send 0x85, 0x3C -> after the 8th SCK rise of byte 1, one strobe with wb_we_o = 1, wb_addr_o = 0x05, wb_dat_o = 0x3C.
4. Ack delayed 3 cycles on a read of 0x7F with wb_dat_i = 0x5A -> strobe high 4 cycles, address stable; MISO returns 0x5A.
5. Abort: SS high after 4 bits of byte 0, then a write 0x81, 0x11 -> no Wishbone cycle for the aborted bytes; write to address 0x01 with data 0x11 completes normally.
6. Back-to-back: read 0x02 then write 0x83, 0xFF under one SS low -> read strobe then write strobe, with correct addresses and data.

Source files
------------

// File: rtl/spi_wb_ctrl_pkg.sv
// Shared types and constants for the SPI-to-Wishbone bridge.
package spi_wb_ctrl_pkg;

    localparam int DATA_W        = 8;
    localparam int BIT_CNT_W     = 3;
    localparam int CMD_WRITE_BIT = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        RD_REQ = 3'd2,
        DATA   = 3'd3,
        WR_REQ = 3'd4
    } state_t;

    // The command byte carries a 7-bit register address; the top address bit is always 0.
    function automatic logic [DATA_W-1:0] cmd_addr(input logic [DATA_W-2:0] a);
        return {1'b0, a};
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// 8-bit shift register shared by the receive and transmit paths of the SPI slave.
// A parallel load takes priority over a shift in the same cycle.
module spi_shift_reg
    import spi_wb_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              serial_in,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] data,
    output logic              serial_out
);

    // Shift MSB-first, or take a parallel value (read data or a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            data <= {data[DATA_W-2:0], serial_in};
        end
    end

    assign serial_out = data[DATA_W-1];

endmodule

// File: rtl/spi_wb_ctrl.sv
// SPI mode-0 slave that turns two-byte transactions (command/address, data)
// into single Wishbone reads and writes. All SPI inputs are oversampled in clk.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | slave select high; bit counter and shift register held at 0
// CMD    | shifting in the command/address byte
// RD_REQ | Wishbone read strobe asserted, waiting for ack
// DATA   | shifting the data byte (read data out / write data in)
// WR_REQ | Wishbone write strobe asserted, waiting for ack
module spi_wb_ctrl
    import spi_wb_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [DATA_W-1:0] wb_addr_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    output logic              wb_we_o
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sck_prev;
    logic                   sck_rise;

    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   byte_done;

    logic [DATA_W-1:0]      sr_q;
    logic [DATA_W-1:0]      rx_byte;
    logic [DATA_W-1:0]      sr_load_data;
    logic                   sr_load;
    logic                   sr_shift;
    logic                   sr_msb;
    logic                   unused_sr_top;

    state_t                 state_q;
    state_t                 state_d;
    logic                   int_cmd;
    logic                   int_cmd_d;
    logic [DATA_W-1:0]      int_addr;
    logic [DATA_W-1:0]      int_addr_d;
    logic                   stb_d;
    logic                   we_d;
    logic [DATA_W-1:0]      addr_d;
    logic [DATA_W-1:0]      dat_d;

    // Input synchronizers; SS resets to the deasserted level so nothing starts out of reset.
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;

    // Bit counter: cleared whenever the slave is deselected, wraps 7 -> 0 at byte end.
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            bit_cnt <= '0;
        end else if (state_q == IDLE || ss_s) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign byte_done = sck_rise && (bit_cnt == '1);

    // The byte as it will stand after this edge's shift, used on the completing edge.
    assign rx_byte  = {sr_q[DATA_W-2:0], mosi_s};
    assign sr_shift = sck_rise && !ss_s && (state_q != IDLE);

    spi_shift_reg u_shift_reg (
        .clk        (clk),
        .rst_n      (wb_rst_i),
        .shift_en   (sr_shift),
        .serial_in  (mosi_s),
        .load       (sr_load),
        .load_data  (sr_load_data),
        .data       (sr_q),
        .serial_out (sr_msb)
    );

    // The top bit reaches the pin through serial_out; the parallel copy is only needed below it.
    assign unused_sr_top = sr_q[DATA_W-1];

    // MISO is gated by the raw select so the line is low as soon as the master lets go.
    assign spi_miso = ~spi_ss & sr_msb;

    // State register.
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, shift-register loads and next values of the registered Wishbone outputs.
    always_comb begin
        state_d      = state_q;
        int_cmd_d    = int_cmd;
        int_addr_d   = int_addr;
        stb_d        = wb_stb_o;
        we_d         = wb_we_o;
        addr_d       = wb_addr_o;
        dat_d        = wb_dat_o;
        sr_load      = 1'b0;
        sr_load_data = '0;

        case (state_q)
            IDLE: begin
                sr_load = 1'b1;
                if (!ss_s) begin
                    state_d = CMD;
                end
            end

            CMD: begin
                if (ss_s) begin
                    state_d = IDLE;
                end else if (byte_done) begin
                    int_cmd_d  = rx_byte[CMD_WRITE_BIT];
                    int_addr_d = cmd_addr(rx_byte[DATA_W-2:0]);
                    if (rx_byte[CMD_WRITE_BIT]) begin
                        state_d = DATA;
                    end else begin
                        state_d = RD_REQ;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = cmd_addr(rx_byte[DATA_W-2:0]);
                    end
                end
            end

            // A strobe already on the bus is always finished, even if SS went away.
            RD_REQ: begin
                if (wb_ack_i) begin
                    stb_d        = 1'b0;
                    sr_load      = 1'b1;
                    sr_load_data = wb_dat_i;
                    state_d      = ss_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (ss_s) begin
                    state_d = IDLE;
                end else if (byte_done) begin
                    if (int_cmd) begin
                        state_d = WR_REQ;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = int_addr;
                        dat_d   = rx_byte;
                    end else begin
                        state_d = CMD;
                    end
                end
            end

            // Clearing the shift register here keeps MISO low for the next command byte.
            WR_REQ: begin
                if (wb_ack_i) begin
                    stb_d   = 1'b0;
                    sr_load = 1'b1;
                    state_d = ss_s ? IDLE : CMD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered Wishbone outputs and the latched command; address/data/we hold after the cycle.
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            int_cmd   <= 1'b0;
            int_addr  <= '0;
        end else begin
            wb_stb_o  <= stb_d;
            wb_we_o   <= we_d;
            wb_addr_o <= addr_d;
            wb_dat_o  <= dat_d;
            int_cmd   <= int_cmd_d;
            int_addr  <= int_addr_d;
        end
    end

endmodule

// File: tb/tb_spi_wb_ctrl.sv
// Self-checking bench for spi_wb_ctrl: a bit-banged SPI master, a Wishbone
// register-file slave with programmable ack delay, and a byte-level model of
// what each SPI session must produce on the bus and on MISO.
module tb_spi_wb_ctrl;

    logic       clk      = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       spi_sck  = 1'b0;
    logic       spi_ss   = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] wb_addr_o;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_stb_o;
    logic       wb_ack_i;
    logic       wb_we_o;

    always #5 clk = ~clk;

    spi_wb_ctrl #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .wb_addr_o (wb_addr_o),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i),
        .wb_we_o   (wb_we_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- Wishbone slave: register file with ack after ack_delay wait states
    logic [7:0] slave_mem [0:127];
    logic [7:0] model_mem [0:127];
    int         ack_delay  = 0;
    int         stb_cycles = 0;
    logic       pl_en   = 1'b0;
    logic [6:0] pl_addr = '0;
    logic [7:0] pl_val  = '0;

    assign wb_ack_i = wb_stb_o && (stb_cycles >= ack_delay);
    assign wb_dat_i = slave_mem[wb_addr_o[6:0]];

    always @(posedge clk) begin
        if (wb_stb_o && !wb_ack_i) stb_cycles <= stb_cycles + 1;
        else                       stb_cycles <= 0;
        if (wb_stb_o && wb_ack_i && wb_we_o) slave_mem[wb_addr_o[6:0]] <= wb_dat_o;
        if (pl_en) slave_mem[pl_addr] <= pl_val;
    end

    task automatic preload(input logic [6:0] a, input logic [7:0] v);
        pl_addr = a;
        pl_val  = v;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en   = 1'b0;
        model_mem[a] = v;
    endtask

    // ---------------- Reference model: expected bus cycles and MISO bits per session
    typedef struct packed {
        logic [7:0] addr;
        logic       we;
        logic [7:0] dat;
    } wb_exp_t;

    wb_exp_t    exp_wb[$];
    bit         exp_miso_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    function automatic void push_bits(input logic [7:0] v, input int nb);
        for (int k = 0; k < nb; k++) exp_miso_q.push_back(v[3'(7 - k)]);
    endfunction

    // A session starts from a cleared shift register; MISO echoes whatever the
    // register held before each byte: the previous data byte after a read, the
    // command byte during a write's data byte, read data during a read's data byte.
    function automatic void model_session(input int nbits);
        int         left = nbits;
        int         i    = 0;
        int         nb;
        logic [7:0] echo = 8'h00;
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] rd   = 8'h00;
        wb_exp_t    e;
        while (i < tx_q.size() && left > 0) begin
            cmd = tx_q[i];
            nb  = (left < 8) ? left : 8;
            push_bits(echo, nb);
            left -= nb;
            if (nb < 8) break;
            if (!cmd[7]) begin
                e.addr = {1'b0, cmd[6:0]};
                e.we   = 1'b0;
                e.dat  = 8'h00;
                exp_wb.push_back(e);
                rd = model_mem[cmd[6:0]];
            end
            if (i + 1 >= tx_q.size() || left == 0) break;
            dat = tx_q[i + 1];
            nb  = (left < 8) ? left : 8;
            push_bits(cmd[7] ? cmd : rd, nb);
            left -= nb;
            if (nb < 8) break;
            if (cmd[7]) begin
                e.addr = {1'b0, cmd[6:0]};
                e.we   = 1'b1;
                e.dat  = dat;
                exp_wb.push_back(e);
                model_mem[cmd[6:0]] = dat;
                echo = 8'h00;
            end else begin
                echo = dat;
            end
            i += 2;
        end
    endfunction

    // ---------------- Compare process: bus cycles, held outputs, MISO while deselected
    bit         mon_en    = 1'b0;
    int         wb_done   = 0;
    int         stb_len   = 0;
    int         last_len  = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_dat  = 8'h00;
    logic       last_we   = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (spi_ss) chk("miso_deselected", 32'(spi_miso), 32'd0);
                if (wb_stb_o) begin
                    stb_len++;
                    if (exp_wb.size() == 0) begin
                        chk("stb_unexpected", 32'(wb_stb_o), 32'd0);
                        if (wb_ack_i) stb_len = 0;
                    end else begin
                        chk("wb_addr", 32'(wb_addr_o), 32'(exp_wb[0].addr));
                        chk("wb_we", 32'(wb_we_o), 32'(exp_wb[0].we));
                        if (exp_wb[0].we) chk("wb_dat", 32'(wb_dat_o), 32'(exp_wb[0].dat));
                        if (wb_ack_i) begin
                            chk("stb_len", 32'(stb_len), 32'(ack_delay + 1));
                            last_len  = stb_len;
                            stb_len   = 0;
                            last_addr = exp_wb[0].addr;
                            last_we   = exp_wb[0].we;
                            if (exp_wb[0].we) last_dat = exp_wb[0].dat;
                            wb_done++;
                            void'(exp_wb.pop_front());
                        end
                    end
                end else begin
                    chk("addr_hold", 32'(wb_addr_o), 32'(last_addr));
                    chk("we_hold", 32'(wb_we_o), 32'(last_we));
                    chk("dat_hold", 32'(wb_dat_o), 32'(last_dat));
                end
            end
        end
    end

    // ---------------- SPI master
    int half = 3;

    task automatic run_session(input int nbits);
        logic [7:0] cur = 8'h00;
        logic [7:0] cur_tx;
        bit         want;
        int         gap = 10 + ack_delay;
        model_session(nbits);
        rx_q.delete();
        @(negedge clk);
        spi_sck = 1'b0;
        spi_ss  = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (b > 0 && b % 8 == 0) repeat (gap) @(negedge clk);
            cur_tx   = tx_q[b / 8];
            spi_mosi = cur_tx[3'(7 - b % 8)];
            repeat (half) @(negedge clk);
            cur  = {cur[6:0], spi_miso};
            want = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 1'b0;
            chk("miso_bit", 32'(spi_miso), 32'(want));
            spi_sck = 1'b1;
            repeat (half) @(negedge clk);
            spi_sck = 1'b0;
            if (b % 8 == 7) rx_q.push_back(cur);
        end
        repeat (half) @(negedge clk);
        spi_ss = 1'b1;
        repeat (gap + 6) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset: outputs all low while held, and no activity after release with SS high.
        #2 wb_rst_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_addr", 32'(wb_addr_o), 32'd0);
        chk("rst_dat", 32'(wb_dat_o), 32'd0);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        for (int i = 0; i < 128; i++) preload(7'(i), 8'($urandom));
        @(negedge clk);
        wb_rst_i = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("post_rst_stb", 32'(wb_stb_o), 32'd0);
        chk("post_rst_miso", 32'(spi_miso), 32'd0);
        mon_en = 1'b1;

        // Read of 0x05 with combinational ack.
        preload(7'h05, 8'hA5);
        ack_delay = 0;
        half      = 3;
        tx_q.delete();
        tx_q.push_back(8'h05);
        tx_q.push_back(8'h00);
        base = wb_done;
        run_session(16);
        chk("t2_rx_count", 32'(rx_q.size()), 32'd2);
        chk("t2_miso_b0", 32'(rx_q[0]), 32'h00);
        chk("t2_miso_b1", 32'(rx_q[1]), 32'hA5);
        chk("t2_wb_count", 32'(wb_done - base), 32'd1);
        chk("t2_addr", 32'(last_addr), 32'h05);
        chk("t2_we", 32'(last_we), 32'd0);
        chk("t2_stb_len", 32'(last_len), 32'd1);

        // Write 0x3C to 0x05.
        tx_q.delete();
        tx_q.push_back(8'h85);
        tx_q.push_back(8'h3C);
        base = wb_done;
        run_session(16);
        chk("t3_wb_count", 32'(wb_done - base), 32'd1);
        chk("t3_we", 32'(last_we), 32'd1);
        chk("t3_addr", 32'(last_addr), 32'h05);
        chk("t3_dat", 32'(last_dat), 32'h3C);
        chk("t3_mem", 32'(slave_mem[5]), 32'h3C);
        chk("t3_miso_b1", 32'(rx_q[1]), 32'h85);

        // Read of 0x7F with three wait states.
        preload(7'h7F, 8'h5A);
        ack_delay = 3;
        tx_q.delete();
        tx_q.push_back(8'h7F);
        tx_q.push_back(8'h00);
        run_session(16);
        chk("t4_miso_b1", 32'(rx_q[1]), 32'h5A);
        chk("t4_stb_len", 32'(last_len), 32'd4);
        chk("t4_addr", 32'(last_addr), 32'h7F);

        // Abort after four bits, then a normal write.
        ack_delay = 1;
        tx_q.delete();
        tx_q.push_back(8'h81);
        tx_q.push_back(8'h11);
        base = wb_done;
        run_session(4);
        chk("t5_abort_no_wb", 32'(wb_done - base), 32'd0);
        run_session(16);
        chk("t5_wb_count", 32'(wb_done - base), 32'd1);
        chk("t5_addr", 32'(last_addr), 32'h01);
        chk("t5_dat", 32'(last_dat), 32'h11);
        chk("t5_mem", 32'(slave_mem[1]), 32'h11);

        // Read then write under one slave select.
        ack_delay = 0;
        preload(7'h02, 8'h96);
        tx_q.delete();
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h83);
        tx_q.push_back(8'hFF);
        base = wb_done;
        run_session(32);
        chk("t6_wb_count", 32'(wb_done - base), 32'd2);
        chk("t6_rd_data", 32'(rx_q[1]), 32'h96);
        chk("t6_miso_cmd2", 32'(rx_q[2]), 32'h00);
        chk("t6_miso_dat2", 32'(rx_q[3]), 32'h83);
        chk("t6_addr", 32'(last_addr), 32'h03);
        chk("t6_dat", 32'(last_dat), 32'hFF);

        // Random sessions: mixed reads/writes to a small address window, random
        // wait states, SCK rates and occasional aborts at any bit.
        for (int s = 0; s < 30; s++) begin
            int ntx;
            int total;
            int nbits;
            ntx       = $urandom_range(1, 3);
            ack_delay = $urandom_range(0, 3);
            half      = $urandom_range(2, 4);
            tx_q.delete();
            for (int t = 0; t < ntx; t++) begin
                tx_q.push_back({1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 15))});
                tx_q.push_back(8'($urandom));
            end
            total = 16 * ntx;
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total - 1) : total;
            run_session(nbits);
        end

        repeat (20) @(negedge clk);
        chk("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
